// File: rtl/sdio_host_cmd_engine.sv
// Host-side SDIO CMD-line engine: CMD5/CMD3/CMD7 enumeration, then single
// CMD52 register accesses, with response timeout, retry and R4/R6/R5 decode.
module sdio_host_cmd_engine #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRIES    = 2,
    parameter int MAX_CMD5_POLLS = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        init_start,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_function,
    input  logic [16:0] req_address,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic [7:0]  rsp_flags,
    output logic        rsp_error,
    output logic [1:0]  error_code,
    output logic        card_ready,
    output logic [15:0] card_rca,
    output logic        busy,
    output logic [37:0] write_data,
    output logic        write_data_strobe,
    input  logic        send_command_in_progress,
    input  logic [37:0] read_data,
    input  logic        read_data_strobe,
    input  logic        read_error
);
    typedef enum logic [2:0] {
        IDLE, SEND, BLIND, TX_WAIT, RSP_WAIT, CHECK, DONE
    } state_t;
    typedef enum logic [2:0] {
        K_CMD5, K_POLL, K_CMD3, K_CMD7, K_CMD52
    } kind_t;

    state_t      state, next_state;
    kind_t       kind;
    logic [37:0] frame, rsp_frame;
    logic        rsp_rerr, rsp_tmo, err_q;
    logic [15:0] tmo_cnt;
    logic [7:0]  retry_cnt, poll_cnt;
    logic [5:0]  exp_idx;
    logic [1:0]  fail_code;
    logic        retry_ok, poll_ready, poll_last, flag_bad, accept;

    assign accept = req_valid && req_ready;

    // Outcome of the attempt whose response (or timeout) was just captured.
    always_comb begin
        unique case (kind)
            K_CMD5, K_POLL: exp_idx = 6'h3F;
            K_CMD3:         exp_idx = 6'd3;
            K_CMD7:         exp_idx = 6'd7;
            default:        exp_idx = 6'd52;
        endcase
        fail_code = 2'd0;
        if (rsp_tmo)
            fail_code = 2'd1;
        else if (rsp_rerr)
            fail_code = 2'd2;
        else if (rsp_frame[37:32] != exp_idx)
            fail_code = 2'd3;
        retry_ok   = retry_cnt < 8'(MAX_RETRIES);
        poll_ready = rsp_frame[31];
        poll_last  = (poll_cnt + 8'd1) >= 8'(MAX_CMD5_POLLS);
        flag_bad   = |(rsp_frame[15:8] & 8'hCB);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (init_start || accept) next_state = SEND;
            SEND:     next_state = BLIND;
            BLIND:    next_state = TX_WAIT;
            TX_WAIT:  if (!send_command_in_progress) next_state = RSP_WAIT;
            RSP_WAIT: begin
                if (read_data_strobe || tmo_cnt == 16'(TIMEOUT_CYCLES))
                    next_state = CHECK;
            end
            CHECK: begin
                if (fail_code != 2'd0)
                    next_state = retry_ok ? SEND :
                                 (kind == K_CMD52) ? DONE : IDLE;
                else begin
                    unique case (kind)
                        K_POLL:  next_state = (poll_ready || !poll_last) ? SEND : IDLE;
                        K_CMD7:  next_state = IDLE;
                        K_CMD52: next_state = DONE;
                        default: next_state = SEND;
                    endcase
                end
            end
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        busy              = state != IDLE;
        write_data_strobe = state == SEND;
        write_data        = frame;
        rsp_valid         = state == DONE;
        rsp_error         = (state == DONE) && err_q;
        req_ready         = card_ready && state == IDLE && !init_start;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            kind       <= K_CMD5;
            frame      <= '0;
            rsp_frame  <= '0;
            rsp_rerr   <= 1'b0;
            rsp_tmo    <= 1'b0;
            tmo_cnt    <= '0;
            retry_cnt  <= '0;
            poll_cnt   <= '0;
            err_q      <= 1'b0;
            card_ready <= 1'b0;
            card_rca   <= '0;
            error_code <= '0;
            rsp_data   <= '0;
            rsp_flags  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (init_start) begin
                        kind       <= K_CMD5;
                        frame      <= {6'd5, 32'd0};
                        retry_cnt  <= '0;
                        poll_cnt   <= '0;
                        card_ready <= 1'b0;
                        card_rca   <= '0;
                        error_code <= '0;
                    end else if (accept) begin
                        kind       <= K_CMD52;
                        frame      <= {6'd52, req_write, req_function, 2'b00,
                                       req_address, 1'b0,
                                       req_write ? req_wdata : 8'h00};
                        retry_cnt  <= '0;
                        err_q      <= 1'b0;
                        error_code <= '0;
                    end
                end
                TX_WAIT:  tmo_cnt <= '0;
                RSP_WAIT: begin
                    // Captured every cycle; the exit cycle's copy is what CHECK sees.
                    tmo_cnt   <= tmo_cnt + 16'd1;
                    rsp_frame <= read_data;
                    rsp_rerr  <= read_error;
                    rsp_tmo   <= !read_data_strobe;
                end
                CHECK: begin
                    if (fail_code != 2'd0) begin
                        if (retry_ok)
                            retry_cnt <= retry_cnt + 8'd1;
                        else begin
                            error_code <= fail_code;
                            err_q      <= 1'b1;
                        end
                    end else begin
                        retry_cnt <= '0;
                        unique case (kind)
                            K_CMD5: begin
                                kind  <= K_POLL;
                                frame <= {6'd5, 32'h003C_0000};
                            end
                            K_POLL: begin
                                if (poll_ready) begin
                                    kind  <= K_CMD3;
                                    frame <= {6'd3, 32'd0};
                                end else if (poll_last)
                                    error_code <= 2'd3;
                                else
                                    poll_cnt <= poll_cnt + 8'd1;
                            end
                            K_CMD3: begin
                                kind     <= K_CMD7;
                                card_rca <= rsp_frame[31:16];
                                frame    <= {6'd7, rsp_frame[31:16], 16'h0};
                            end
                            K_CMD7:  card_ready <= 1'b1;
                            default: begin
                                rsp_data  <= rsp_frame[7:0];
                                rsp_flags <= rsp_frame[15:8];
                                err_q     <= flag_bad;
                                if (flag_bad) error_code <= 2'd3;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sdio_host_cmd_engine.sv
// Scoreboard bench for sdio_host_cmd_engine: a scripted slave answers each
// command frame, and a monitor checks frames and CMD52 responses.
module tb_sdio_host_cmd_engine;
    localparam int TMO = 1024;

    typedef struct {
        logic [7:0] data;
        logic [7:0] flags;
        logic       err;
        logic [1:0] code;
        logic       chk;
    } rsp_t;
    typedef struct {
        bit          resp;
        logic [37:0] frame;
        bit          rerr;
        int          delay;
    } plan_t;

    logic        clock = 0, reset_n = 0;
    logic        init_start = 0, req_valid = 0, req_write = 0;
    logic [2:0]  req_function = 0;
    logic [16:0] req_address = 0;
    logic [7:0]  req_wdata = 0;
    logic        req_ready, rsp_valid, rsp_error, card_ready, busy;
    logic [7:0]  rsp_data, rsp_flags;
    logic [1:0]  error_code;
    logic [15:0] card_rca;
    logic [37:0] write_data;
    logic        write_data_strobe;
    logic        send_command_in_progress = 0;
    logic [37:0] read_data = 0;
    logic        read_data_strobe = 0, read_error = 0;

    int vectors = 0, miscompares = 0, cyc = 0;
    logic [37:0] exp_frames[$];
    rsp_t        exp_rsp[$];
    plan_t       plan[$];

    sdio_host_cmd_engine dut (
        .clock(clock), .reset_n(reset_n), .init_start(init_start),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_function(req_function), .req_address(req_address),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .rsp_error(rsp_error), .error_code(error_code),
        .card_ready(card_ready), .card_rca(card_rca), .busy(busy),
        .write_data(write_data), .write_data_strobe(write_data_strobe),
        .send_command_in_progress(send_command_in_progress),
        .read_data(read_data), .read_data_strobe(read_data_strobe),
        .read_error(read_error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every frame and every CMD52 completion must be expected.
    logic [37:0] mf;
    rsp_t        me;
    always @(negedge clock) begin
        if (write_data_strobe) begin
            if (exp_frames.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_frame: got %0h, expected none", write_data);
            end else begin
                mf = exp_frames.pop_front();
                check("frame", write_data, mf);
            end
        end
        if (rsp_valid) begin
            if (exp_rsp.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_rsp_valid: got 1, expected 0");
            end else begin
                me = exp_rsp.pop_front();
                check("rsp_error", rsp_error, me.err);
                check("rsp_code", error_code, me.code);
                if (me.chk) begin
                    check("rsp_data", rsp_data, me.data);
                    check("rsp_flags", rsp_flags, me.flags);
                end
            end
        end
    end

    // Slave model: consumes one plan entry per command frame.
    plan_t sp;
    initial begin
        forever begin
            @(negedge clock);
            if (write_data_strobe) begin
                if (plan.size() == 0) sp = '{0, 38'h0, 0, 1};
                else sp = plan.pop_front();
                send_command_in_progress = 1;
                repeat ($urandom_range(1, 5)) @(negedge clock);
                send_command_in_progress = 0;
                if (sp.resp) begin
                    repeat (sp.delay) @(negedge clock);
                    read_data = sp.frame;
                    read_error = sp.rerr;
                    read_data_strobe = 1;
                    @(negedge clock);
                    read_data_strobe = 0;
                    read_error = 0;
                end
            end
        end
    end

    task automatic say(logic [37:0] fr, bit rerr);
        plan.push_back('{1, fr, rerr, $urandom_range(3, 30)});
    endtask
    task automatic mute();
        plan.push_back('{0, 38'h0, 0, 1});
    endtask

    task automatic wait_idle(string name, int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        check({name, "_idle"}, busy, 0);
    endtask

    task automatic pulse_init();
        @(negedge clock);
        init_start = 1;
        @(negedge clock);
        init_start = 0;
    endtask

    task automatic enum_ok(logic [15:0] rca);
        exp_frames.push_back({6'd5, 32'h0});
        exp_frames.push_back({6'd5, 32'h003C0000});
        exp_frames.push_back({6'd3, 32'h0});
        exp_frames.push_back({6'd7, 32'(rca) * 32'h10000});
        say({6'h3F, 32'h00FF8000}, 0);
        say({6'h3F, 32'h80FF8000}, 0);
        say({6'd3, rca, 16'h1E00}, 0);
        say({6'd7, 32'h00001E00}, 0);
    endtask

    // Reference frame: pushes the expected frame nsends times, then drives the request.
    task automatic cmd52(bit w, logic [2:0] fn, logic [16:0] addr,
                         logic [7:0] d, int nsends, rsp_t r);
        logic [31:0] arg;
        int n = 0;
        arg = 32'(w) * 32'h8000_0000 + 32'(fn) * 32'h1000_0000
            + 32'(addr) * 32'd512 + (w ? 32'(d) : 32'd0);
        repeat (nsends) exp_frames.push_back({6'd52, arg});
        exp_rsp.push_back(r);
        @(negedge clock);
        req_valid = 1; req_write = w; req_function = fn;
        req_address = addr; req_wdata = d;
        #1;
        while (!req_ready && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("req_ready", req_ready, 1);
        @(negedge clock);
        req_valid = 0;
    endtask

    task automatic wait_rsp(string name, int budget);
        int n = 0;
        while (exp_rsp.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check({name, "_rsp_seen"}, exp_rsp.size(), 0);
        wait_idle(name, 50);
    endtask

    initial begin
        logic [7:0] fl, rd;
        bit w, bad, glitch;
        int t0;
        rsp_t r;

        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_strobe", write_data_strobe, 0);
        check("rst_wdata", write_data, 0);
        check("rst_card_ready", card_ready, 0);
        check("rst_req_ready", req_ready, 0);
        reset_n = 1;
        repeat (2) @(negedge clock);

        // CMD5 poll never ready: 1 + MAX_CMD5_POLLS frames, then code 3.
        exp_frames.push_back({6'd5, 32'h0});
        say({6'h3F, 32'h00FF8000}, 0);
        repeat (16) begin
            exp_frames.push_back({6'd5, 32'h003C0000});
            say({6'h3F, 32'h00FF8000}, 0);
        end
        pulse_init();
        wait_idle("poll_fail", 3000);
        check("poll_fail_ready", card_ready, 0);
        check("poll_fail_code", error_code, 3);
        check("poll_fail_frames", exp_frames.size(), 0);

        enum_ok(16'h2AB1);
        pulse_init();
        wait_idle("enum", 1000);
        check("enum_ready", card_ready, 1);
        check("enum_rca", card_rca, 16'h2AB1);
        check("enum_code", error_code, 0);

        say({6'd52, 32'h0000_1032}, 0);
        cmd52(0, 3'd0, 17'h0, 8'h00, 1, '{8'h32, 8'h10, 0, 0, 1});
        wait_rsp("read0", 200);

        say({6'd52, 32'h0000_0040}, 0);
        cmd52(1, 3'd0, 17'h110, 8'h40, 1, '{8'h40, 8'h00, 0, 0, 1});
        wait_rsp("write110", 200);

        repeat (3) mute();
        cmd52(0, 3'd1, 17'h7, 8'h00, 3, '{8'h0, 8'h0, 1, 1, 0});
        t0 = cyc;
        wait_rsp("timeout", 4000);
        check("timeout_span", (cyc - t0 >= 3 * TMO) && (cyc - t0 < 3 * TMO + 200), 1);

        say({6'd52, 32'h0000_0099}, 1);
        say({6'd52, 32'h0000_2055}, 0);
        cmd52(0, 3'd2, 17'h1FFFF, 8'h00, 2, '{8'h55, 8'h20, 0, 0, 1});
        wait_rsp("crc_retry", 300);

        say({6'd52, 32'h0000_0211}, 0);
        cmd52(1, 3'd7, 17'h0ABCD, 8'hA5, 1, '{8'h11, 8'h02, 1, 3, 1});
        wait_rsp("flag_err", 200);

        repeat (3) say({6'd52, 32'h0}, 1);
        cmd52(0, 3'd3, 17'h3, 8'h00, 3, '{8'h0, 8'h0, 1, 2, 0});
        wait_rsp("crc_fail", 500);

        repeat (3) say({6'd5, 32'h0}, 0);
        cmd52(0, 3'd3, 17'h4, 8'h00, 3, '{8'h0, 8'h0, 1, 3, 0});
        wait_rsp("idx_fail", 500);

        for (int i = 0; i < 24; i++) begin
            w = 1'($urandom);
            rd = 8'($urandom);
            fl = ($urandom % 2) ? 8'($urandom) : (8'($urandom) & 8'h34);
            bad = (fl & 8'hCB) != 8'h00;
            glitch = ($urandom % 4) == 0;
            if (glitch) say({6'd52, 16'($urandom), fl, rd}, 1);
            say({6'd52, 16'($urandom), fl, rd}, 0);
            r = '{rd, fl, bad, bad ? 2'd3 : 2'd0, 1};
            cmd52(w, 3'($urandom), 17'($urandom), 8'($urandom),
                  glitch ? 2 : 1, r);
            wait_rsp("random", 300);
        end

        // init_start and req_valid together: init wins.
        @(negedge clock);
        init_start = 1;
        req_valid = 1;
        #1 check("init_wins_ready", req_ready, 0);
        enum_ok(16'h5A5A);
        @(negedge clock);
        init_start = 0;
        req_valid = 0;
        wait_idle("reenum", 1000);
        check("reenum_rca", card_rca, 16'h5A5A);
        check("reenum_ready", card_ready, 1);

        // Reset during RSP_WAIT, then a late strobe: no rsp_valid.
        plan.push_back('{1, {6'd52, 32'h0000_0077}, 0, 300});
        exp_frames.push_back({6'd52, 32'h1000_0A00});
        @(negedge clock);
        req_valid = 1; req_write = 0; req_function = 3'd1;
        req_address = 17'h5; req_wdata = 8'hFF;
        @(negedge clock);
        req_valid = 0;
        repeat (30) @(negedge clock);
        check("pre_reset_busy", busy, 1);
        reset_n = 0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_ready", card_ready, 0);
        check("arst_rca", card_rca, 0);
        check("arst_req_ready", req_ready, 0);
        check("arst_code", error_code, 0);
        check("arst_wdata", write_data, 0);
        check("arst_rsp_data", rsp_data, 0);
        repeat (3) @(negedge clock);
        check("arst_strobe", write_data_strobe, 0);
        reset_n = 1;
        repeat (400) @(negedge clock);
        check("late_busy", busy, 0);
        check("late_req_ready", req_ready, 0);
        check("frames_left", exp_frames.size(), 0);
        check("plan_left", plan.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
